// File: rtl/edge_event_scheduler_if.sv
// Event-delivery bundle between the edge scheduler (master) and its consumer (slave).
// The master side samples din/mask/event_ready and drives the event and status outputs.
interface edge_event_scheduler_if #(
  parameter int unsigned WIDTH = 32
);
  localparam int unsigned IdW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] mask;
  logic             event_ready;
  logic             event_valid;
  logic [IdW-1:0]   event_id;
  logic [WIDTH-1:0] pending;
  logic [CntW-1:0]  pend_count;
  logic             overflow;

  modport master (
    input  din, mask, event_ready,
    output event_valid, event_id, pending, pend_count, overflow
  );

  modport slave (
    output din, mask, event_ready,
    input  event_valid, event_id, pending, pend_count, overflow
  );
endinterface

// File: rtl/edge_event_scheduler.sv
// Falling-edge capture into sticky pending flags, served one at a time by a
// round-robin scheduler over a valid/ready handshake.
module edge_event_scheduler #(
  parameter int unsigned WIDTH = 32
) (
  input logic                    clk,
  input logic                    reset,
  edge_event_scheduler_if.master bus
);
  localparam int unsigned IdW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {StIdle, StPresent} state_e;

  state_e           r_state, w_state_d;
  logic [WIDTH-1:0] r_prev, r_pending, w_pending_d;
  logic [WIDTH-1:0] w_fall, w_clr, w_elig, w_elig_excl, w_id_onehot;
  logic             r_overflow, w_overflow_d;
  logic [IdW-1:0]   r_id, w_id_d, r_ptr, w_ptr_d, w_next_ptr;
  logic [CntW-1:0]  r_count;
  logic             w_hs;

  // First set bit of req at or above start, wrapping modulo WIDTH.
  function automatic logic [IdW-1:0] rr_pick(input logic [WIDTH-1:0] req,
                                             input logic [IdW-1:0]   start);
    logic [IdW-1:0] pick;
    logic [IdW-1:0] idx;
    logic           found;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      idx = IdW'((32'(start) + k) % WIDTH);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_comb begin
    w_fall       = r_prev & ~bus.din;
    w_hs         = (r_state == StPresent) && bus.event_ready;
    w_id_onehot  = WIDTH'(1) << r_id;
    w_clr        = w_hs ? w_id_onehot : '0;
    w_pending_d  = (r_pending & ~w_clr) | w_fall;
    w_overflow_d = r_overflow | (|(w_fall & r_pending & ~w_clr));
    // Grant decisions use registered pending, so fresh edges wait one cycle.
    w_elig       = r_pending & bus.mask;
    w_elig_excl  = w_elig & ~w_id_onehot;
    w_next_ptr   = (r_id == IdW'(WIDTH - 1)) ? '0 : r_id + 1'b1;
  end

  always_comb begin
    w_state_d = r_state;
    w_id_d    = r_id;
    w_ptr_d   = r_ptr;
    unique case (r_state)
      StIdle: begin
        if (|w_elig) begin
          w_id_d    = rr_pick(w_elig, r_ptr);
          w_state_d = StPresent;
        end
      end
      StPresent: begin
        if (w_hs) begin
          w_ptr_d = w_next_ptr;
          if (|w_elig_excl) begin
            w_id_d = rr_pick(w_elig_excl, w_next_ptr);
          end else begin
            w_state_d = StIdle;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    r_prev <= bus.din;
    if (reset) begin
      r_state    <= StIdle;
      r_pending  <= '0;
      r_overflow <= 1'b0;
      r_id       <= '0;
      r_ptr      <= '0;
      r_count    <= '0;
    end else begin
      r_state    <= w_state_d;
      r_pending  <= w_pending_d;
      r_overflow <= w_overflow_d;
      r_id       <= w_id_d;
      r_ptr      <= w_ptr_d;
      r_count    <= CntW'($countones(w_pending_d));
    end
  end

  assign bus.event_valid = (r_state == StPresent);
  assign bus.event_id    = r_id;
  assign bus.pending     = r_pending;
  assign bus.pend_count  = r_count;
  assign bus.overflow    = r_overflow;
endmodule

// File: tb/tb_edge_event_scheduler.sv
// Directed scenarios plus a random soak for edge_event_scheduler, checked against
// constants and an event-level reference model.
module tb_edge_event_scheduler;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  edge_event_scheduler_if #(.WIDTH(32)) bus ();

  edge_event_scheduler #(.WIDTH(32)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  // Reference model state (current and next).
  logic [31:0] m_prev, m_pend, n_prev, n_pend;
  logic        m_ovf, m_valid, n_ovf, n_valid;
  logic [4:0]  m_id, m_ptr, n_id, n_ptr;

  function automatic logic [4:0] pick(input logic [31:0] req, input logic [4:0] start);
    logic [4:0] idx;
    for (int k = 0; k < 32; k++) begin
      idx = 5'((int'(start) + k) % 32);
      if (req[idx]) return idx;
    end
    return 5'd0;
  endfunction

  task automatic model_eval();
    logic [31:0] fall, clr, elig, rest;
    logic        hs;
    logic [4:0]  np;
    fall   = m_prev & ~bus.din;
    hs     = m_valid & bus.event_ready;
    clr    = hs ? (32'd1 << m_id) : 32'd0;
    n_prev = bus.din;
    if (reset) begin
      n_pend = '0; n_ovf = 1'b0; n_valid = 1'b0; n_id = '0; n_ptr = '0;
    end else begin
      n_pend  = (m_pend & ~clr) | fall;
      n_ovf   = m_ovf | (|(fall & m_pend & ~clr));
      n_valid = m_valid; n_id = m_id; n_ptr = m_ptr;
      elig    = m_pend & bus.mask;
      if (!m_valid) begin
        if (elig != 0) begin
          n_valid = 1'b1;
          n_id    = pick(elig, m_ptr);
        end
      end else if (hs) begin
        np    = m_id + 5'd1;
        n_ptr = np;
        rest  = elig & ~(32'd1 << m_id);
        if (rest != 0) n_id = pick(rest, np);
        else n_valid = 1'b0;
      end
    end
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    #1;
    m_prev = n_prev; m_pend = n_pend; m_ovf = n_ovf;
    m_valid = n_valid; m_id = n_id; m_ptr = n_ptr;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.din = '0; bus.mask = '1; bus.event_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    total++;
    if (bus.event_valid !== 1'b0) begin
      bad++; $display("FAIL reset_valid got=%b want=0", bus.event_valid);
    end
    total++;
    if (bus.pending !== 32'h0 || bus.pend_count !== 6'd0) begin
      bad++; $display("FAIL reset_pending got=%h/%0d want=0/0", bus.pending, bus.pend_count);
    end
    total++;
    if (bus.overflow !== 1'b0 || bus.event_id !== 5'd0) begin
      bad++; $display("FAIL reset_ovf_id got=%b/%0d want=0/0", bus.overflow, bus.event_id);
    end
  endtask

  task automatic test_single_edge();
    do_reset();
    bus.event_ready = 1'b1;
    bus.din = 32'h2; tick();
    bus.din = 32'h0; tick();
    total++;
    if (bus.pending !== 32'h2 || bus.pend_count !== 6'd1 || bus.event_valid !== 1'b0) begin
      bad++; $display("FAIL single_capture got=%h/%0d/%b want=2/1/0",
                      bus.pending, bus.pend_count, bus.event_valid);
    end
    tick();
    total++;
    if (bus.event_valid !== 1'b1 || bus.event_id !== 5'd1) begin
      bad++; $display("FAIL single_present got=%b/%0d want=1/1", bus.event_valid, bus.event_id);
    end
    tick();
    total++;
    if (bus.event_valid !== 1'b0 || bus.pending !== 32'h0 || bus.pend_count !== 6'd0 ||
        bus.overflow !== 1'b0) begin
      bad++; $display("FAIL single_done got=%b/%h/%0d/%b want=0/0/0/0", bus.event_valid,
                      bus.pending, bus.pend_count, bus.overflow);
    end
  endtask

  task automatic test_round_robin();
    logic [4:0] exp_a [3];
    logic [4:0] exp_b [4];
    exp_a = '{5'd1, 5'd2, 5'd3};
    exp_b = '{5'd2, 5'd3, 5'd0, 5'd1};
    do_reset();
    bus.event_ready = 1'b1;
    bus.din = 32'hE; tick();
    bus.din = 32'h0; tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (bus.event_valid !== 1'b1 || bus.event_id !== exp_a[i]) begin
        bad++; $display("FAIL rr_first[%0d] got=%b/%0d want=1/%0d", i, bus.event_valid,
                        bus.event_id, exp_a[i]);
      end
    end
    tick();
    total++;
    if (bus.event_valid !== 1'b0) begin
      bad++; $display("FAIL rr_first_end got=%b want=0", bus.event_valid);
    end
    // Serve bit 1 first so the pointer sits at 2.
    do_reset();
    bus.din = 32'h2; tick();
    bus.din = 32'h0; tick();
    tick();
    tick();
    bus.din = 32'hF; tick();
    bus.din = 32'h0; tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (bus.event_valid !== 1'b1 || bus.event_id !== exp_b[i]) begin
        bad++; $display("FAIL rr_wrap[%0d] got=%b/%0d want=1/%0d", i, bus.event_valid,
                        bus.event_id, exp_b[i]);
      end
    end
    tick();
    total++;
    if (bus.event_valid !== 1'b0 || bus.pending !== 32'h0) begin
      bad++; $display("FAIL rr_wrap_end got=%b/%h want=0/0", bus.event_valid, bus.pending);
    end
  endtask

  task automatic test_stall_mask();
    do_reset();
    bus.event_ready = 1'b0; bus.mask = '1;
    bus.din = 32'h10; tick();
    bus.din = 32'h0; tick();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) bus.mask = ~32'h10;
      tick();
      total++;
      if (bus.event_valid !== 1'b1 || bus.event_id !== 5'd4) begin
        bad++; $display("FAIL stall[%0d] got=%b/%0d want=1/4", i, bus.event_valid, bus.event_id);
      end
    end
    bus.mask = '1; bus.event_ready = 1'b1;
    tick();
    total++;
    if (bus.event_valid !== 1'b0 || bus.pending !== 32'h0) begin
      bad++; $display("FAIL stall_accept got=%b/%h want=0/0", bus.event_valid, bus.pending);
    end
    bus.mask = '0;
    bus.din = 32'h20; tick();
    bus.din = 32'h0; tick();
    tick();
    tick();
    total++;
    if (bus.pending !== 32'h20 || bus.event_valid !== 1'b0) begin
      bad++; $display("FAIL masked got=%h/%b want=20/0", bus.pending, bus.event_valid);
    end
    bus.mask = 32'h20;
    tick();
    total++;
    if (bus.event_valid !== 1'b1 || bus.event_id !== 5'd5) begin
      bad++; $display("FAIL unmask got=%b/%0d want=1/5", bus.event_valid, bus.event_id);
    end
    tick();
    bus.mask = '1;
  endtask

  task automatic test_overflow();
    do_reset();
    bus.event_ready = 1'b0;
    bus.din = 32'h1; tick();
    bus.din = 32'h0; tick();
    tick();
    bus.din = 32'h1; tick();
    bus.din = 32'h0; tick();
    total++;
    if (bus.overflow !== 1'b1 || bus.pending !== 32'h1) begin
      bad++; $display("FAIL ovf_set got=%b/%h want=1/1", bus.overflow, bus.pending);
    end
    // Edge coinciding with the handshake of the same bit.
    do_reset();
    bus.din = 32'h1; tick();
    bus.din = 32'h0; tick();
    tick();
    bus.din = 32'h1; tick();
    bus.din = 32'h0; bus.event_ready = 1'b1; tick();
    bus.event_ready = 1'b0;
    total++;
    if (bus.pending !== 32'h1 || bus.overflow !== 1'b0 || bus.event_valid !== 1'b0) begin
      bad++; $display("FAIL same_cycle got=%h/%b/%b want=1/0/0", bus.pending, bus.overflow,
                      bus.event_valid);
    end
    tick();
    total++;
    if (bus.event_valid !== 1'b1 || bus.event_id !== 5'd0) begin
      bad++; $display("FAIL represent got=%b/%0d want=1/0", bus.event_valid, bus.event_id);
    end
    bus.event_ready = 1'b1; tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.event_ready = 1'b0;
    bus.din = 32'h30; tick();
    bus.din = 32'h0; tick();
    tick();
    bus.din = 32'h20; tick();
    total++;
    if (bus.event_valid !== 1'b1 || bus.pending !== 32'h30) begin
      bad++; $display("FAIL mid_pre got=%b/%h want=1/30", bus.event_valid, bus.pending);
    end
    reset = 1'b1; bus.din = 32'h0; tick();
    reset = 1'b0;
    total++;
    if (bus.event_valid !== 1'b0 || bus.event_id !== 5'd0 || bus.pending !== 32'h0 ||
        bus.pend_count !== 6'd0 || bus.overflow !== 1'b0) begin
      bad++; $display("FAIL mid_reset got=%b/%0d/%h/%0d/%b want=0/0/0/0/0", bus.event_valid,
                      bus.event_id, bus.pending, bus.pend_count, bus.overflow);
    end
    tick();
    total++;
    if (bus.pending !== 32'h0) begin
      bad++; $display("FAIL reset_edge_dropped got=%h want=0", bus.pending);
    end
    reset = 1'b1; bus.din = 32'h20; tick();
    reset = 1'b0; bus.din = 32'h0; tick();
    total++;
    if (bus.pending !== 32'h20) begin
      bad++; $display("FAIL post_reset_edge got=%h want=20", bus.pending);
    end
  endtask

  task automatic test_random_soak();
    do_reset();
    for (int c = 0; c < 200; c++) begin
      reset = ($urandom_range(15) == 0);
      bus.din = bus.din ^ ($urandom & $urandom & $urandom);
      if ($urandom_range(7) == 0) bus.mask = ($urandom_range(1) == 0) ? 32'($urandom) : '1;
      bus.event_ready = 1'($urandom_range(1));
      if (bus.event_valid && bus.event_ready && !reset) begin
        total++;
        if (bus.pending[bus.event_id] !== 1'b1) begin
          bad++; $display("FAIL soak_accept_pending c=%0d id=%0d pending=%h", c, bus.event_id,
                          bus.pending);
        end
      end
      tick();
      total++;
      if (bus.event_valid !== m_valid || bus.event_id !== m_id || bus.pending !== m_pend ||
          bus.overflow !== m_ovf || bus.pend_count !== 6'($countones(m_pend))) begin
        bad++; $display("FAIL soak c=%0d got v=%b id=%0d p=%h o=%b n=%0d want v=%b id=%0d p=%h o=%b n=%0d",
                        c, bus.event_valid, bus.event_id, bus.pending, bus.overflow,
                        bus.pend_count, m_valid, m_id, m_pend, m_ovf, $countones(m_pend));
      end
      total++;
      if (bus.pend_count !== 6'($countones(bus.pending))) begin
        bad++; $display("FAIL soak_popcount c=%0d got=%0d want=%0d", c, bus.pend_count,
                        $countones(bus.pending));
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    m_prev = '0; m_pend = '0; m_ovf = 1'b0; m_valid = 1'b0; m_id = '0; m_ptr = '0;
    test_reset();
    test_single_edge();
    test_round_robin();
    test_stall_mask();
    test_overflow();
    test_reset_mid();
    test_random_soak();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/edge_event_scheduler.md
# edge_event_scheduler

Captures falling edges on a 32-bit input bus into per-bit sticky pending flags. A round-robin scheduler then delivers the pending events one at a time to a single consumer over a valid/ready handshake, clearing each flag as it is accepted. The block sits between the raw edge-capture datapath and the event-servicing logic, so that simultaneous edges are serialised fairly instead of being read as one 32-bit word.

## Interface
Parameters:
- WIDTH, 32, number of input bits; event_id width is $clog2(WIDTH).

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-high.
- din  input  WIDTH  monitored bus, sampled every posedge.
- mask  input  WIDTH  1 = bit eligible for scheduling; pending capture is unaffected.
- event_ready  input  1  consumer accepts the presented event.
- event_valid  output  1  an event is being presented (registered).
- event_id  output  5  index of the presented bit (registered).
- pending  output  WIDTH  current sticky pending flags.
- pend_count  output  6  population count of pending (registered).
- overflow  output  1  sticky: an edge arrived on a bit already pending.

## Operation
- Edge detect:
  - prev <= din every cycle, including during reset.
  - fall[i] = prev[i] & ~din[i].
- Pending update:
  - pending[i] <= (pending[i] & ~clr[i]) | fall[i].
  - clr[i] is high only on an accepted handshake (event_valid & event_ready) for event_id==i.
  - An edge and a clear on the same bit in the same cycle leave the bit set. This counts as a new event, not an overflow.
- Overflow:
  - Set when fall[i] & pending[i] & ~clr[i] for any i.
  - Cleared only by reset.
- Eligibility: elig = pending & mask, using registered values.
- States:
  - IDLE (event_valid=0): if elig != 0, grant the first set bit at or above ptr, wrapping modulo WIDTH. Load event_id, set event_valid, go to PRESENT. Otherwise stay in IDLE.
  - PRESENT (event_valid=1): event_id is held stable while event_ready=0. Mask changes do not retract a presented event.
  - On handshake in PRESENT: ptr <= event_id+1 (wraps WIDTH-1 -> 0).
    - If elig with bit event_id excluded is nonzero, grant the next bit (search from event_id+1, wrapping) and stay in PRESENT.
    - Otherwise go to IDLE.
- Edges detected in the current cycle are not eligible for grant until the following cycle.
- pend_count tracks popcount(pending) with the same one-cycle registration as pending.
- Reset:
  - pending=0, overflow=0, event_valid=0, event_id=0, ptr=0, pend_count=0, state IDLE.
  - Reset asserted during PRESENT drops the event with no handshake.
  - Edges in the reset cycle are discarded, but prev still updates.

## Timing
- din falls at posedge n (prev=1, din=0) -> pending[i]=1 after posedge n.
- Earliest event_valid: after posedge n+1, i.e. 2 cycles after the sampled edge.
- Back-to-back: with event_ready held high and several bits eligible, one event is accepted per cycle.
- event_valid deasserts the cycle after the last accepted handshake.
- Rising edges never set pending. A bit held low produces no repeat events.
- Round-robin fairness: a continuously pending bit is granted within WIDTH grants.

## Test plan
- Single edge: din 0x2 -> 0x0, mask=all-ones, event_ready=1.
  - pending=0x2 the next cycle, then event_valid=1 with event_id=1 for one cycle.
  - Afterwards pending=0, pend_count=0, overflow=0.
- Multi-edge round robin: din 0xE -> 0x0 with event_ready=1 continuously.
  - Events 1, 2, 3 on consecutive cycles, then event_valid=0.
  - Repeat with ptr=2 (after serving bit 1) and din 0xF -> 0x0: order is 2, 3, 0, 1.
- Stall and mask: din 0x10 -> 0x0 with event_ready=0.
  - event_id=4 is held valid and stable for 5 cycles; dropping mask[4] mid-stall does not retract it.
  - Separately, with mask=0 and edge on bit 5: pending=0x20 and event_valid stays 0. Setting mask[5]=1 gives event_id=5 one cycle later.
- Overflow and simultaneous clear:
  - Edge on bit 0, pulse din[0] high then low again before acceptance: overflow=1, pending=0x1.
  - Edge on bit 0 in the same cycle its handshake completes: pending[0] stays 1, overflow unchanged, and event_id=0 is presented again.
- Reset mid-operation:
  - Reset asserted while event_valid=1 with pending=0x30: next cycle all outputs are 0.
  - An edge on bit 5 during the reset cycle is not captured. An edge on bit 5 in the first cycle after reset is captured.
- Random soak: 200 cycles of random din, ~1/16 reset density, random event_ready.
  - Compare against a cycle-accurate model.
  - Check that each accepted event_id had a pending bit set, and that pend_count == popcount(pending).
